// File: rtl/tse_config_sequencer.sv
// Avalon-MM master that brings the triple-speed Ethernet MAC out of reset:
// soft reset, reset poll, station address, frame length, enable and verify.
module tse_config_sequencer #(
  parameter logic [47:0] MAC_ADDR   = 48'h001C_2317_4ACB,
  parameter int unsigned MAX_FRAME  = 1518,
  parameter int unsigned POLL_LIMIT = 255,
  parameter int unsigned WAIT_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] status
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RST_WR  = 4'd1,
    S_POLL_RD = 4'd2,
    S_MAC0_WR = 4'd3,
    S_MAC1_WR = 4'd4,
    S_FRM_WR  = 4'd5,
    S_CFG_WR  = 4'd6,
    S_VFY_RD  = 4'd7,
    S_DONE    = 4'd8,
    S_ERROR   = 4'd9
  } state_e;

  localparam int unsigned SCW         = $clog2(WAIT_LIMIT + 1);
  localparam logic [SCW-1:0] STALL_MAX = SCW'(WAIT_LIMIT - 1);
  localparam logic [11:0] POLL_MAX    = 12'(POLL_LIMIT);
  localparam logic [31:0] MAX_FRAME_W = 32'(MAX_FRAME);
  localparam logic [31:0] MAC0_DATA   = {MAC_ADDR[23:16], MAC_ADDR[31:24],
                                         MAC_ADDR[39:32], MAC_ADDR[47:40]};
  localparam logic [31:0] MAC1_DATA   = {16'h0000, MAC_ADDR[7:0], MAC_ADDR[15:8]};
  localparam logic [31:0] FRM_DATA    = {16'h0000, MAX_FRAME_W[15:0]};

  state_e         state_q, state_d, nxt_s;
  logic           rd_q, rd_d, wr_q, wr_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [SCW-1:0] stall_q, stall_d;
  logic [11:0]    poll_q, poll_d;
  logic [15:0]    last_q, last_d;
  logic           done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic           strobe_s, step_s;
  logic           unused_s;

  // Bus transaction owned by each state as {read, write, address, writedata}
  function automatic logic [41:0] txn_of(input state_e s);
    logic [41:0] t;
    case (s)
      S_RST_WR:  t = {1'b0, 1'b1, 8'h02, 32'h0000_2000};
      S_POLL_RD: t = {1'b1, 1'b0, 8'h02, 32'h0000_0000};
      S_MAC0_WR: t = {1'b0, 1'b1, 8'h03, MAC0_DATA};
      S_MAC1_WR: t = {1'b0, 1'b1, 8'h04, MAC1_DATA};
      S_FRM_WR:  t = {1'b0, 1'b1, 8'h05, FRM_DATA};
      S_CFG_WR:  t = {1'b0, 1'b1, 8'h02, 32'h0000_0013};
      S_VFY_RD:  t = {1'b1, 1'b0, 8'h02, 32'h0000_0000};
      default:   t = 42'd0;
    endcase
    return t;
  endfunction

  function automatic logic is_busy(input state_e s);
    return (s != S_IDLE) && (s != S_DONE) && (s != S_ERROR);
  endfunction

  assign strobe_s = rd_q | wr_q;
  assign unused_s = ^avm_readdata[31:16];

  // Next-state, next bus transaction and flag/counter updates
  always_comb begin
    state_d = state_q;
    nxt_s   = state_q;
    step_s  = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    stall_d = stall_q;
    poll_d  = poll_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_RST_WR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          poll_d  = 12'd0;
          last_d  = 16'h0000;
          stall_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_RST_WR, S_POLL_RD, S_MAC0_WR, S_MAC1_WR, S_FRM_WR, S_CFG_WR, S_VFY_RD: begin
        // The first transaction launches one cycle after start; later ones chain on accept
        if (!strobe_s) begin
          {rd_d, wr_d, addr_d, data_d} = txn_of(state_q);
          stall_d = '0;
        end else if (avm_waitrequest) begin
          if (stall_q == STALL_MAX) begin
            nxt_s  = S_ERROR;
            step_s = 1'b1;
          end else begin
            stall_d = stall_q + SCW'(1);
          end
        end else begin
          step_s  = 1'b1;
          stall_d = '0;
          case (state_q)
            S_RST_WR:  nxt_s = S_POLL_RD;
            S_POLL_RD: begin
              last_d = avm_readdata[15:0];
              if (avm_readdata[13]) begin
                if (poll_q == POLL_MAX) begin
                  nxt_s = S_ERROR;
                end else begin
                  poll_d = poll_q + 12'd1;
                  nxt_s  = S_POLL_RD;
                end
              end else begin
                nxt_s = S_MAC0_WR;
              end
            end
            S_MAC0_WR: nxt_s = S_MAC1_WR;
            S_MAC1_WR: nxt_s = S_FRM_WR;
            S_FRM_WR:  nxt_s = S_CFG_WR;
            S_CFG_WR:  nxt_s = S_VFY_RD;
            S_VFY_RD: begin
              last_d = avm_readdata[15:0];
              if (avm_readdata[4:0] == 5'b10011) begin
                nxt_s = S_DONE;
              end else begin
                nxt_s = S_ERROR;
              end
            end
            default:   nxt_s = S_ERROR;
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        {rd_d, wr_d, addr_d, data_d} = 42'd0;
      end
    endcase
    if (step_s) begin
      state_d = nxt_s;
      {rd_d, wr_d, addr_d, data_d} = txn_of(nxt_s);
      done_d  = (nxt_s == S_DONE);
      err_d   = (nxt_s == S_ERROR);
      busy_d  = is_busy(nxt_s);
    end else begin
      busy_d  = is_busy(state_d);
    end
  end

  // State and registered bus/flag outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 32'h0000_0000;
      stall_q <= '0;
      poll_q  <= 12'd0;
      last_q  <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      poll_q  <= poll_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign status        = {state_q, poll_q, last_q};

endmodule

// File: tb/tb_tse_config_sequencer.sv
// Directed bench for tse_config_sequencer with a small responding Avalon slave.
module tb_tse_config_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, error;
  logic [31:0] status;

  int tests = 0;
  int fails = 0;
  int n0 = 0;
  int lat;

  // Slave behaviour knobs, driven by the stimulus
  int          poll_set_n = 0;
  int          stall_n = 0;
  logic [7:0]  stall_addr = 8'hFF;
  logic [31:0] vfy_val = 32'h0000_0013;

  // Monitor state
  int          cyc = 0;
  int          both_cnt = 0;
  int          polls_seen = 0;
  int          stalls_seen = 0;
  logic        cfg_written = 1'b0;
  int          log_n = 0;
  logic [7:0]  log_addr [32];
  logic [31:0] log_data [32];
  logic        log_rd   [32];

  tse_config_sequencer #(.POLL_LIMIT(4), .WAIT_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .error(error), .status(status)
  );

  always #5 clk = ~clk;

  assign avm_waitrequest = (avm_read | avm_write) && (avm_address == stall_addr) &&
                           (stalls_seen < stall_n);

  always_comb begin
    if (cfg_written) avm_readdata = vfy_val;
    else if (polls_seen < poll_set_n) avm_readdata = 32'h0000_2000;
    else avm_readdata = 32'h0000_0000;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read && avm_write) both_cnt <= both_cnt + 1;
    if (start && !busy) begin
      polls_seen  <= 0;
      stalls_seen <= 0;
      cfg_written <= 1'b0;
      log_n       <= 0;
    end else begin
      if ((avm_read || avm_write) && avm_waitrequest) stalls_seen <= stalls_seen + 1;
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (log_n < 32) begin
          log_addr[log_n] <= avm_address;
          log_data[log_n] <= avm_writedata;
          log_rd[log_n]   <= avm_read;
          log_n           <= log_n + 1;
        end
        if (avm_read && !cfg_written) polls_seen <= polls_seen + 1;
        if (avm_write && avm_address == 8'h02 && avm_writedata == 32'h0000_0013)
          cfg_written <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    n0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output int l);
    int k = 0;
    while (!(done || error) && k < 300) begin
      @(negedge clk);
      k++;
    end
    l = cyc - n0;
    check("end_reached", {31'd0, done | error}, 32'd1);
  endtask

  task automatic wait_wr(input logic [7:0] a);
    int k = 0;
    while (!(avm_write && avm_address == a) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wr_seen", {31'd0, avm_write && avm_address == a}, 32'd1);
  endtask

  task automatic check_nominal_log(input string pfx);
    logic [7:0]  ea;
    logic [31:0] ed;
    logic        er;
    check({pfx, "_count"}, log_n, 32'd7);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin ea = 8'h02; ed = 32'h0000_2000; er = 1'b0; end
        1: begin ea = 8'h02; ed = 32'h0000_0000; er = 1'b1; end
        2: begin ea = 8'h03; ed = 32'h1723_1C00; er = 1'b0; end
        3: begin ea = 8'h04; ed = 32'h0000_CB4A; er = 1'b0; end
        4: begin ea = 8'h05; ed = 32'h0000_05EE; er = 1'b0; end
        5: begin ea = 8'h02; ed = 32'h0000_0013; er = 1'b0; end
        default: begin ea = 8'h02; ed = 32'h0000_0000; er = 1'b1; end
      endcase
      check($sformatf("%s_addr%0d", pfx, i), {24'd0, log_addr[i]}, {24'd0, ea});
      check($sformatf("%s_rd%0d", pfx, i), {31'd0, log_rd[i]}, {31'd0, er});
      if (!er) check($sformatf("%s_data%0d", pfx, i), log_data[i], ed);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_write", {31'd0, avm_write}, 32'd0);
    check("rst_addr", {24'd0, avm_address}, 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_status", status, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal run
    run_start();
    check("nom_busy", {31'd0, busy}, 32'd1);
    wait_end(lat);
    check("nom_lat", lat, 32'd8);
    check("nom_flags", {29'd0, busy, done, error}, 32'b010);
    check("nom_status", status, 32'h8000_0013);
    check_nominal_log("nom");

    // Three busy polls before reset clears
    poll_set_n = 3;
    run_start();
    wait_end(lat);
    check("poll3_lat", lat, 32'd11);
    check("poll3_status", status, 32'h8003_0013);
    check("poll3_count", log_n, 32'd10);
    check("poll3_mac0_pos", {24'd0, log_addr[5]}, 32'h03);
    poll_set_n = 0;

    // Five stalled cycles on MAC1_WR
    stall_addr = 8'h04;
    stall_n = 5;
    run_start();
    wait_wr(8'h04);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_wr%0d", i), {31'd0, avm_write}, 32'd1);
      check($sformatf("stall_addr%0d", i), {24'd0, avm_address}, 32'h04);
      check($sformatf("stall_data%0d", i), avm_writedata, 32'h0000_CB4A);
      @(negedge clk);
    end
    wait_end(lat);
    check("stall_lat", lat, 32'd13);
    check("stall_flags", {29'd0, busy, done, error}, 32'b010);
    stall_n = 0;

    // Poll never clears
    poll_set_n = 100;
    run_start();
    wait_end(lat);
    check("ptmo_lat", lat, 32'd7);
    check("ptmo_flags", {29'd0, busy, done, error}, 32'b001);
    check("ptmo_status", status, 32'h9004_2000);
    check("ptmo_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    poll_set_n = 0;

    // Verify mismatch, then a clean rerun
    vfy_val = 32'h0000_0003;
    run_start();
    wait_end(lat);
    check("vfy_lat", lat, 32'd8);
    check("vfy_flags", {29'd0, busy, done, error}, 32'b001);
    check("vfy_status", status, 32'h9000_0003);
    vfy_val = 32'h0000_0013;
    run_start();
    wait_end(lat);
    check("rerun_flags", {29'd0, busy, done, error}, 32'b010);
    check("rerun_status", status, 32'h8000_0013);

    // Asynchronous reset during a stalled FRM_WR
    stall_addr = 8'h05;
    stall_n = 100;
    run_start();
    wait_wr(8'h05);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    check("arst_status", status, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stall_n = 0;
    repeat (3) @(negedge clk);
    check("arst_idle_status", status, 32'd0);
    check("arst_idle_write", {30'd0, avm_read, avm_write}, 32'd0);

    // start while busy is ignored
    run_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(lat);
    check("sbusy_lat", lat, 32'd8);
    check("sbusy_flags", {29'd0, busy, done, error}, 32'b010);
    check_nominal_log("sbusy");

    // waitrequest stuck on MAC0_WR
    stall_addr = 8'h03;
    stall_n = 100;
    run_start();
    wait_end(lat);
    check("wtmo_lat", lat, 32'd11);
    check("wtmo_flags", {29'd0, busy, done, error}, 32'b001);
    check("wtmo_status", status, 32'h9000_0000);
    check("wtmo_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    stall_n = 0;

    check("rd_wr_exclusive", both_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tse_config_sequencer.md
# tse_config_sequencer

Sequencer that brings up the triple-speed Ethernet MAC after reset by acting as an Avalon-MM master on the MAC control register port. It issues a fixed, ordered set of register transactions. The sequence is: soft reset, poll for reset completion, program the station MAC address and maximum frame length, then enable TX/RX in promiscuous 100 Mb/s mode and read back to verify. It sits beside the MAC in the sniffer top level and exposes done/error flags plus a 32-bit status word that drives the hex display.

## Interface
- MAC_ADDR, 48'h00_1C_23_17_4A_CB, station address; byte 0 (first on wire) is MAC_ADDR[47:40]
- MAX_FRAME, 1518, value written to frm_length (16 bits used)
- POLL_LIMIT, 255, max reads of command_config while waiting for SW_RESET to clear (≤ 4095)
- WAIT_LIMIT, 1023, max consecutive cycles a single transaction may be stalled by avm_waitrequest

- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled request to run the sequence
- avm_address  out  8  MAC register word address
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave stall
- busy  out  1  sequence in progress
- done  out  1  sequence completed and verified (sticky until next start or reset)
- error  out  1  sequence aborted (sticky until next start or reset)
- status  out  32  {state[3:0], poll_count[11:0], last_readdata[15:0]}

One clock; reset is asynchronous and active-high.

## Operation
- States and codes: IDLE 0, RST_WR 1, POLL_RD 2, MAC0_WR 3, MAC1_WR 4, FRM_WR 5, CFG_WR 6, VFY_RD 7, DONE 8, ERROR 9.
- Transactions:
  - RST_WR: write addr 0x02 data 0x0000_2000 (SW_RESET).
  - POLL_RD: read addr 0x02. If bit 13 = 1, increment poll_count and reread. If bit 13 = 0, go to MAC0_WR.
  - MAC0_WR: write addr 0x03 data {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]}.
  - MAC1_WR: write addr 0x04 data {16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]}.
  - FRM_WR: write addr 0x05 data {16'h0, MAX_FRAME[15:0]}.
  - CFG_WR: write addr 0x02 data 0x0000_0013 (TX_ENA, RX_ENA, PROMIS_EN; ETH_SPEED=0).
  - VFY_RD: read addr 0x02. If readdata[4:0] = 5'b10011, go to DONE; otherwise go to ERROR.
- Poll timeout: if a poll read still sees bit 13 = 1 after poll_count reaches POLL_LIMIT, go to ERROR.
- Stall timeout: a stall counter resets at each new transaction. If it reaches WAIT_LIMIT with waitrequest still 1, drop the strobe and go to ERROR.
- start=1 in IDLE, DONE or ERROR: clear done, error, poll_count and last_readdata, then enter RST_WR. start is ignored while busy.
- last_readdata captures readdata[15:0] on every accepted read.
- busy = 1 in states 1–7.

## Timing
- Reset values: avm_read/avm_write 0, avm_address 0, avm_writedata 0, busy/done/error 0, status 0, state IDLE.
- Strobe, address and data are registered. They are held constant while avm_waitrequest=1.
- A transaction is accepted on the edge where strobe=1 and waitrequest=0. The next transaction's strobe is asserted in the very next cycle (no gap).
- Read and write are never asserted together.
- Latency with waitrequest tied 0 and the poll clearing on the first read:
  - start sampled at edge N; RST_WR strobe is high in cycle N+1.
  - 7 transactions occupy cycles N+1..N+7.
  - done=1 and busy=0 from edge N+8.
- Each stalled cycle adds exactly one cycle. Each extra poll adds exactly one cycle.
- done/error assert on the same edge the state enters DONE/ERROR. All strobes are 0 in DONE, ERROR and IDLE.
- rst asserted mid-transaction drops the strobes immediately (asynchronously) and returns to IDLE. There is no automatic restart.

## Test plan
- Nominal, waitrequest=0, poll returns 0x0000_0000, verify returns 0x0000_0013:
  - write sequence is addr/data 02/00002000, 03/17231C00, 04/0000CB4A, 05/000005EE, 02/00000013;
  - done=1 at start+8, status[31:28]=8.
- Poll returns bit 13 set for 3 reads, then clear: 4 reads of 0x02, status[27:16]=3, done at start+11.
- waitrequest held high for 5 cycles on MAC1_WR: address, data and strobe are stable throughout; done is delayed by 5 cycles; error stays 0.
- Poll never clears (readdata=0x2000), POLL_LIMIT=4: error=1 after the 5th poll read, status[31:28]=9, strobes 0.
- Verify reads 0x0000_0003: error=1, done=0, status[15:0]=0x0003. A subsequent start reruns the full sequence and reaches done.
- Additional cases:
  - rst pulsed during FRM_WR stall: strobes go 0 immediately and state is IDLE.
  - start pulsed while busy: no effect on the transaction order.
  - waitrequest stuck for WAIT_LIMIT cycles: error=1.
